// File: rtl/rv32_isa.sv
// rtl/rv32_isa.sv - RV32I encoder types: instruction formats, check codes, immediate ranges
package rv32_isa;

    // Instruction formats; encodings 6 and 7 are deliberately left unnamed (illegal).
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // Check result; numerically larger codes win when several apply.
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_ALIGN   = 2'd2,
        ERR_ILLEGAL = 2'd3
    } enc_err_e;

    // Signed byte-offset limits. B and J maxima are even because bit 0 is not encoded.
    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX =  32'sd2047;
    localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
    localparam logic signed [31:0] IMMB_MAX  =  32'sd4094;
    localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
    localparam logic signed [31:0] IMMJ_MAX  =  32'sd1048574;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/rv32_imm_pack.sv
// rtl/rv32_imm_pack.sv - scatters an immediate into instruction bits [31:7] and checks it
//
// Purpose: combinational immediate packer for the RV32I encoder.
// Ports:
//   fmt       in   3   instruction format (fmt_e encoding, 6/7 illegal)
//   imm       in   32  signed byte-offset immediate (U: full upper value)
//   imm_bits  out  25  immediate contribution to instruction bits [31:7];
//                      zero wherever the format places register/funct fields
//   err       out  2   format/alignment/range check result (enc_err_e)
module rv32_imm_pack
    import rv32_isa::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic [24:0] imm_bits,
    output enc_err_e    err
);

    logic signed [31:0] simm;
    assign simm = imm;

    // imm_bits[k] lands on instruction bit k+7.
    always_comb begin
        imm_bits = '0;
        case (fmt)
            FMT_I: imm_bits[24:13] = imm[11:0];
            FMT_S: begin
                imm_bits[24:18] = imm[11:5];
                imm_bits[4:0]   = imm[4:0];
            end
            FMT_B: begin
                imm_bits[24]    = imm[12];
                imm_bits[23:18] = imm[10:5];
                imm_bits[4:1]   = imm[4:1];
                imm_bits[0]     = imm[11];
            end
            FMT_U: imm_bits[24:5] = imm[31:12];
            FMT_J: begin
                imm_bits[24]    = imm[20];
                imm_bits[23:14] = imm[10:1];
                imm_bits[13]    = imm[11];
                imm_bits[12:5]  = imm[19:12];
            end
            default: imm_bits = '0;
        endcase
    end

    // Alignment is tested before range so an odd offset reports as misaligned
    // even when it also lies outside the encodable window.
    always_comb begin
        err = ERR_NONE;
        case (fmt)
            FMT_R: err = ERR_NONE;
            FMT_I, FMT_S: begin
                if (!in_range(simm, IMM12_MIN, IMM12_MAX)) err = ERR_RANGE;
            end
            FMT_B: begin
                if (imm[0])                                 err = ERR_ALIGN;
                else if (!in_range(simm, IMMB_MIN, IMMB_MAX)) err = ERR_RANGE;
            end
            FMT_U: begin
                if (imm[11:0] != 12'd0) err = ERR_ALIGN;
            end
            FMT_J: begin
                if (imm[0])                                 err = ERR_ALIGN;
                else if (!in_range(simm, IMMJ_MIN, IMMJ_MAX)) err = ERR_RANGE;
            end
            default: err = ERR_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/rv32_encoder.sv
// rtl/rv32_encoder.sv - two-stage pipelined RV32I instruction encoder with field checks
//
// Purpose: packs opcode/register/funct/immediate fields into a 32-bit RV32I word.
//   S1 holds accepted fields, S2 holds the encoded word and its check result.
//   Rejected requests are delivered as NOP_WORD with oErr set.
// Ports:
//   iClk, iRst            clock, synchronous active-high reset
//   iValid / oReady       request handshake
//   iFmt, iOpCode, iRD, iRS1, iRS2, iFunc3, iFunc7, iImm   request fields
//   oValid / iReady       result handshake
//   oIns, oErr, oErrCode  encoded word and check result
//   oErrCnt               saturating count of delivered rejected words
module rv32_encoder
    import rv32_isa::*;
#(
    parameter int          ERR_CNT_W = 16,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic [2:0]           iFmt,
    input  logic [6:0]           iOpCode,
    input  logic [4:0]           iRD,
    input  logic [4:0]           iRS1,
    input  logic [4:0]           iRS2,
    input  logic [2:0]           iFunc3,
    input  logic [6:0]           iFunc7,
    input  logic [31:0]          iImm,
    output logic                 oValid,
    input  logic                 iReady,
    output logic [31:0]          oIns,
    output logic                 oErr,
    output logic [1:0]           oErrCode,
    output logic [ERR_CNT_W-1:0] oErrCnt
);

    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [6:0]  s1_op;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;
    logic [6:0]  s1_f7;
    logic [31:0] s1_imm;

    logic        s2_adv;
    logic        s1_adv;

    logic [24:0] imm_bits;
    logic [24:0] reg_bits;
    enc_err_e    pack_err;
    enc_err_e    enc_err;
    logic [31:0] enc_word;

    // S2 frees up when empty or being consumed; S1 can then move forward.
    assign s2_adv = !oValid || iReady;
    assign s1_adv = !s1_valid || s2_adv;
    assign oReady = s1_adv;

    rv32_imm_pack u_imm_pack (
        .fmt      (s1_fmt),
        .imm      (s1_imm),
        .imm_bits (imm_bits),
        .err      (pack_err)
    );

    // Register/funct fields for instruction bits [31:7]; positions the format
    // gives to the immediate stay zero so they can be OR-ed with imm_bits.
    always_comb begin
        reg_bits = '0;
        case (s1_fmt)
            FMT_R:        reg_bits = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd};
            FMT_I:        reg_bits = {12'd0, s1_rs1, s1_f3, s1_rd};
            FMT_S, FMT_B: reg_bits = {7'd0, s1_rs2, s1_rs1, s1_f3, 5'd0};
            FMT_U, FMT_J: reg_bits = {20'd0, s1_rd};
            default:      reg_bits = '0;
        endcase
    end

    assign enc_word = {imm_bits | reg_bits, s1_op};

    // Every RV32I major opcode ends in 2'b11; anything else is a compressed
    // or reserved encoding and outranks immediate problems.
    always_comb begin
        enc_err = pack_err;
        if (s1_op[1:0] != 2'b11) enc_err = ERR_ILLEGAL;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1_valid <= 1'b0;
            s1_fmt   <= '0;
            s1_op    <= '0;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_f3    <= '0;
            s1_f7    <= '0;
            s1_imm   <= '0;
            oValid   <= 1'b0;
            oIns     <= '0;
            oErr     <= 1'b0;
            oErrCode <= '0;
            oErrCnt  <= '0;
        end else begin
            if (oValid && iReady && oErr && (oErrCnt != {ERR_CNT_W{1'b1}})) begin
                oErrCnt <= oErrCnt + ERR_CNT_W'(1);
            end

            if (s1_adv) begin
                s1_valid <= iValid;
                if (iValid) begin
                    s1_fmt <= iFmt;
                    s1_op  <= iOpCode;
                    s1_rd  <= iRD;
                    s1_rs1 <= iRS1;
                    s1_rs2 <= iRS2;
                    s1_f3  <= iFunc3;
                    s1_f7  <= iFunc7;
                    s1_imm <= iImm;
                end
            end

            if (s2_adv) begin
                oValid <= s1_valid;
                if (s1_valid) begin
                    oIns     <= (enc_err != ERR_NONE) ? NOP_WORD : enc_word;
                    oErr     <= (enc_err != ERR_NONE);
                    oErrCode <= enc_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_encoder.sv
// tb/tb_rv32_encoder.sv - self-checking bench for rv32_encoder with a queue-based reference model
module tb_rv32_encoder;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    logic [2:0]  iFmt;
    logic [6:0]  iOpCode;
    logic [4:0]  iRD, iRS1, iRS2;
    logic [2:0]  iFunc3;
    logic [6:0]  iFunc7;
    logic [31:0] iImm;
    logic        oValid;
    logic        iReady;
    logic [31:0] oIns;
    logic        oErr;
    logic [1:0]  oErrCode;
    logic [15:0] oErrCnt;

    always #5 iClk = ~iClk;

    rv32_encoder #(.ERR_CNT_W(16), .NOP_WORD(32'h0000_0013)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iFmt(iFmt), .iOpCode(iOpCode), .iRD(iRD), .iRS1(iRS1), .iRS2(iRS2),
        .iFunc3(iFunc3), .iFunc7(iFunc7), .iImm(iImm),
        .oValid(oValid), .iReady(iReady), .oIns(oIns), .oErr(oErr),
        .oErrCode(oErrCode), .oErrCnt(oErrCnt)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        int          acc;
        logic        has_lit;
        logic [31:0] lit;
        logic [1:0]  lit_code;
    } item_t;

    int    checks = 0;
    int    failures = 0;
    item_t q[$];
    int    edge_cnt = 0;
    int    last_hs = 0;
    int    exp_cnt = 0;
    logic        cur_has_lit = 1'b0;
    logic [31:0] cur_lit = '0;
    logic [1:0]  cur_code = '0;
    bit    rdy_rand = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input int fmt, input int op, input int rd, input int rs1,
                                 input int rs2, input int f3, input int f7, input int imm);
        item_t t;
        t.fmt = 3'(fmt); t.op = 7'(op); t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
        t.f3 = 3'(f3); t.f7 = 7'(f7); t.imm = 32'(imm);
        t.acc = 0; t.has_lit = 1'b0; t.lit = '0; t.lit_code = '0;
        return t;
    endfunction

    // Check code from the rules: illegal > misaligned > out of range.
    function automatic logic [1:0] exp_code(input item_t t);
        int si;
        si = $signed(t.imm);
        if (t.fmt > 3'd5 || t.op[1:0] != 2'b11) return 2'd3;
        case (t.fmt)
            3'd1, 3'd2: return (si < -2048 || si > 2047) ? 2'd1 : 2'd0;
            3'd3: begin
                if (t.imm[0]) return 2'd2;
                return (si < -4096 || si > 4094) ? 2'd1 : 2'd0;
            end
            3'd4: return (t.imm[11:0] != 12'd0) ? 2'd2 : 2'd0;
            3'd5: begin
                if (t.imm[0]) return 2'd2;
                return (si < -1048576 || si > 1048574) ? 2'd1 : 2'd0;
            end
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] encode(input item_t t);
        logic [31:0] m;
        m = t.imm;
        if (exp_code(t) != 2'd0) return 32'h0000_0013;
        case (t.fmt)
            3'd0: return {t.f7, t.rs2, t.rs1, t.f3, t.rd, t.op};
            3'd1: return {m[11:0], t.rs1, t.f3, t.rd, t.op};
            3'd2: return {m[11:5], t.rs2, t.rs1, t.f3, m[4:0], t.op};
            3'd3: return {m[12], m[10:5], t.rs2, t.rs1, t.f3, m[4:1], m[11], t.op};
            3'd4: return {m[31:12], t.rd, t.op};
            default: return {m[20], m[10:1], m[11], m[19:12], t.rd, t.op};
        endcase
    endfunction

    // Independent decoder: pull fields back out of a word and compare to the request.
    function automatic bit round_trip_ok(input item_t t, input logic [31:0] w);
        bit ok;
        logic [31:0] di;
        ok = (w[6:0] == t.op);
        case (t.fmt)
            3'd0: ok = ok && w[11:7] == t.rd && w[19:15] == t.rs1 && w[24:20] == t.rs2
                          && w[14:12] == t.f3 && w[31:25] == t.f7;
            3'd1: begin
                di = {{20{w[31]}}, w[31:20]};
                ok = ok && w[11:7] == t.rd && w[19:15] == t.rs1 && w[14:12] == t.f3 && di == t.imm;
            end
            3'd2: begin
                di = {{20{w[31]}}, w[31:25], w[11:7]};
                ok = ok && w[24:20] == t.rs2 && w[19:15] == t.rs1 && w[14:12] == t.f3 && di == t.imm;
            end
            3'd3: begin
                di = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                ok = ok && w[24:20] == t.rs2 && w[19:15] == t.rs1 && w[14:12] == t.f3 && di == t.imm;
            end
            3'd4: begin
                di = {w[31:12], 12'd0};
                ok = ok && w[11:7] == t.rd && di == t.imm;
            end
            default: begin
                di = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                ok = ok && w[11:7] == t.rd && di == t.imm;
            end
        endcase
        return ok;
    endfunction

    always @(posedge iClk) edge_cnt <= edge_cnt + 1;

    always @(posedge iClk) begin
        if (rdy_rand) begin
            #1;
            iReady = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference: FIFO of requests in flight. A word becomes visible one edge after
    // its acceptance or at the edge its predecessor is consumed, whichever is later;
    // at most two words are in flight.
    int    n, st;
    bit    vis, exp_rdy;
    item_t cur, nw;
    logic [1:0] code;
    always @(negedge iClk) begin
        if (iRst) begin
            q.delete();
            last_hs = 0;
            exp_cnt = 0;
        end else begin
            n = q.size();
            vis = 0;
            if (n > 0) begin
                st = q[0].acc + 1;
                if (last_hs > st) st = last_hs;
                vis = (edge_cnt >= st);
            end
            exp_rdy = (n < 2) || (iReady === 1'b1);
            chk("o_ready", 32'(oReady), 32'(exp_rdy));
            chk("o_valid", 32'(oValid), 32'(vis));
            chk("o_err_cnt", 32'(oErrCnt), 32'(exp_cnt));
            if (vis) begin
                cur = q[0];
                code = exp_code(cur);
                chk("o_ins", oIns, encode(cur));
                chk("o_err", 32'(oErr), 32'(code != 2'd0));
                chk("o_err_code", 32'(oErrCode), 32'(code));
                if (cur.has_lit) begin
                    chk("lit_ins", oIns, cur.lit);
                    chk("lit_code", 32'(oErrCode), 32'(cur.lit_code));
                end
                if (iReady === 1'b1) begin
                    if (code == 2'd0) chk("round_trip", 32'(round_trip_ok(cur, oIns)), 32'd1);
                    void'(q.pop_front());
                    last_hs = edge_cnt + 1;
                    if (code != 2'd0 && exp_cnt != 65535) exp_cnt++;
                end
            end
            if (iValid === 1'b1 && exp_rdy) begin
                nw = mk(int'(iFmt), int'(iOpCode), int'(iRD), int'(iRS1), int'(iRS2),
                        int'(iFunc3), int'(iFunc7), int'(iImm));
                nw.acc = edge_cnt + 1;
                nw.has_lit = cur_has_lit;
                nw.lit = cur_lit;
                nw.lit_code = cur_code;
                q.push_back(nw);
            end
        end
    end

    task automatic drive(input item_t t);
        iFmt = t.fmt; iOpCode = t.op; iRD = t.rd; iRS1 = t.rs1; iRS2 = t.rs2;
        iFunc3 = t.f3; iFunc7 = t.f7; iImm = t.imm;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input item_t t, input logic has_lit, input logic [31:0] lit,
                        input logic [1:0] lcode);
        bit done;
        done = 0;
        drive(t);
        cur_has_lit = has_lit; cur_lit = lit; cur_code = lcode;
        iValid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge iClk);
            if (oReady === 1'b1) done = 1;
            @(posedge iClk); #1;
        end
        iValid = 1'b0;
        cur_has_lit = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && q.size() != 0; i++) @(negedge iClk);
        chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge iClk); #1;
    endtask

    function automatic item_t rand_item();
        item_t t;
        int v;
        int edges[12] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, -4098,
                          1048574, -1048576, 1048576, 4095};
        t = mk($urandom_range(0, 5), 0, $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127), 0);
        if ($urandom_range(0, 9) == 0) t.fmt = 3'($urandom_range(6, 7));
        t.op = {5'($urandom_range(0, 31)), 2'b11};
        if ($urandom_range(0, 9) == 0) t.op = 7'($urandom_range(0, 127));
        case (t.fmt)
            3'd1, 3'd2: v = int'($urandom_range(0, 4095)) - 2048;
            3'd3:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            3'd4:       v = int'($urandom & 32'hFFFF_F000);
            3'd5:       v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            default:    v = int'($urandom);
        endcase
        if ($urandom_range(0, 6) == 0) v = edges[$urandom_range(0, 11)];
        if ($urandom_range(0, 12) == 0) v = int'($urandom);
        t.imm = 32'(v);
        return t;
    endfunction

    item_t bp[4];
    int    k;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        iRst = 1'b1; iValid = 1'b0; iReady = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge iClk);
        #1 iRst = 1'b0;

        @(negedge iClk);
        chk("rst_o_valid", 32'(oValid), 32'd0);
        chk("rst_o_ins", oIns, 32'd0);
        chk("rst_o_err", 32'(oErr), 32'd0);
        chk("rst_o_err_code", 32'(oErrCode), 32'd0);
        chk("rst_o_err_cnt", 32'(oErrCnt), 32'd0);
        chk("rst_o_ready", 32'(oReady), 32'd1);
        @(posedge iClk); #1;

        // Known encodings, back to back.
        send(mk(1, 7'h13, 1, 0, 0, 0, 0, 5),       1'b1, 32'h0050_0093, 2'd0);
        send(mk(0, 7'h33, 3, 1, 2, 0, 0, 0),       1'b1, 32'h0020_81B3, 2'd0);
        send(mk(3, 7'h63, 0, 0, 0, 0, 0, -8),      1'b1, 32'hFE00_0CE3, 2'd0);
        send(mk(5, 7'h6F, 1, 0, 0, 0, 0, 2048),    1'b1, 32'h0010_00EF, 2'd0);
        drain();

        // Rejections.
        send(mk(1, 7'h13, 1, 0, 0, 0, 0, 4096),    1'b1, 32'h0000_0013, 2'd1);
        send(mk(3, 7'h63, 0, 0, 0, 0, 0, 3),       1'b1, 32'h0000_0013, 2'd2);
        send(mk(7, 7'h33, 0, 0, 0, 0, 0, 0),       1'b1, 32'h0000_0013, 2'd3);
        drain();
        @(negedge iClk);
        chk("err_cnt_three", 32'(oErrCnt), 32'd3);
        @(posedge iClk); #1;

        // Backpressure: output stalled for five cycles, four requests offered.
        iReady = 1'b0;
        for (int i = 0; i < 4; i++) bp[i] = mk(1, 7'h13, i + 1, i, 0, 0, 0, 100 * i);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            drive(bp[k < 4 ? k : 3]);
            iValid = 1'b1;
            @(negedge iClk);
            if (oReady === 1'b1) k++;
            @(posedge iClk); #1;
        end
        iValid = 1'b0;
        @(negedge iClk);
        chk("bp_accepted", 32'(k), 32'd2);
        chk("bp_ready_low", 32'(oReady), 32'd0);
        chk("bp_held_ins", oIns, 32'h0000_0093);
        @(posedge iClk); #1;
        iReady = 1'b1;
        for (int i = 2; i < 4; i++) send(bp[i], 1'b0, '0, '0);
        drain();

        // Reset with both stages full.
        iReady = 1'b0;
        send(mk(0, 7'h33, 5, 6, 7, 0, 0, 0), 1'b0, '0, '0);
        send(mk(7, 7'h33, 0, 0, 0, 0, 0, 0), 1'b0, '0, '0);
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        iReady = 1'b1;
        @(negedge iClk);
        chk("midrst_o_valid", 32'(oValid), 32'd0);
        chk("midrst_err_cnt", 32'(oErrCnt), 32'd0);
        chk("midrst_o_ready", 32'(oReady), 32'd1);
        @(posedge iClk); #1;
        drive(mk(1, 7'h13, 1, 0, 0, 0, 0, 5));
        cur_has_lit = 1'b1; cur_lit = 32'h0050_0093; cur_code = 2'd0;
        iValid = 1'b1;
        @(posedge iClk); #1;
        iValid = 1'b0;
        cur_has_lit = 1'b0;
        @(negedge iClk);
        chk("lat_one_edge", 32'(oValid), 32'd0);
        @(negedge iClk);
        chk("lat_two_edges", 32'(oValid), 32'd1);
        chk("lat_o_ins", oIns, 32'h0050_0093);
        @(posedge iClk); #1;
        drain();

        // Randomized traffic with random output backpressure.
        rdy_rand = 1;
        for (int i = 0; i < 600; i++) begin
            send(rand_item(), 1'b0, '0, '0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge iClk); #1;
            end
        end
        drain();
        rdy_rand = 0;
        @(posedge iClk); #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
